// File: rtl/requan_seq_ctrl_pkg.sv
// Shared DLA requantization package: parameter record, sequencer states and
// common widths used by the requantization sequencer and its parameter table.
package requan_seq_ctrl_pkg;

    localparam int HWORD  = 16;
    localparam int CH_MAX = 16;

    typedef struct packed {
        logic [15:0] mult;
        logic [4:0]  shift;
        logic [7:0]  zp;
    } requan_param_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/requan_param_tbl.sv
// Per-channel requantization parameter register file: one write port and two
// asynchronous read ports (Requan1 channel and stage-register channel).
module requan_param_tbl
    import requan_seq_ctrl_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  requan_param_t wdata,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output requan_param_t rdata_a,
    output requan_param_t rdata_b
);

    requan_param_t mem_q [DEPTH];
    requan_param_t mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_a = mem_q[raddr_a];
    assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/requan_seq_ctrl.sv
// Requantization sequencer: tile FSM, element counters, valid/channel pipeline
// aligned with Requan1/Requan2, and the shared stall for both pipeline registers.
module requan_seq_ctrl #(
    parameter int CH_MAX = requan_seq_ctrl_pkg::CH_MAX,
    parameter int CW     = $clog2(CH_MAX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [CW-1:0] cfg_idx,
    input  logic [15:0]   cfg_mult,
    input  logic [4:0]    cfg_shift,
    input  logic [7:0]    cfg_zp,
    output logic          cfg_err,
    input  logic          start,
    input  logic [CW:0]   num_ch,
    input  logic [15:0]   num_out,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          stall,
    output logic          s1_valid,
    output logic          s2_valid,
    output logic [15:0]   p1_mult,
    output logic [4:0]    p2_shift,
    output logic [7:0]    p2_zp,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
);

    import requan_seq_ctrl_pkg::*;

    seq_state_t       state_q, state_d;
    logic [CW:0]      num_ch_q, num_ch_d;
    logic [HWORD-1:0] num_out_q, num_out_d;
    logic [HWORD-1:0] in_cnt_q, in_cnt_d;
    logic [HWORD-1:0] out_cnt_q, out_cnt_d;
    logic [CW-1:0]    ch_in_q, ch_in_d;
    logic [CW-1:0]    ch1_q, ch1_d;
    logic             s1_valid_q, s1_valid_d;
    logic             s2_valid_q, s2_valid_d;
    logic             cfg_err_q, cfg_err_d;

    logic             in_fire;
    logic             out_fire;
    logic             tbl_we;
    requan_param_t    cfg_word;
    requan_param_t    p1_param;
    requan_param_t    p2_param;

    assign stall    = s2_valid_q & ~out_ready;
    assign in_ready = (state_q == RUN) & ~stall & (in_cnt_q < num_out_q);
    assign in_fire  = in_valid & in_ready;
    assign out_fire = s2_valid_q & out_ready;

    // Table writes are only legal while no tile is in flight.
    assign tbl_we   = cfg_we & (state_q == IDLE);
    assign cfg_word = '{mult: cfg_mult, shift: cfg_shift, zp: cfg_zp};

    requan_param_tbl #(
        .DEPTH (CH_MAX),
        .AW    (CW)
    ) u_tbl (
        .clk     (clk),
        .rst     (rst),
        .we      (tbl_we),
        .waddr   (cfg_idx),
        .wdata   (cfg_word),
        .raddr_a (ch_in_q),
        .raddr_b (ch1_q),
        .rdata_a (p1_param),
        .rdata_b (p2_param)
    );

    always_comb begin
        state_d    = state_q;
        num_ch_d   = num_ch_q;
        num_out_d  = num_out_q;
        in_cnt_d   = in_cnt_q;
        out_cnt_d  = out_cnt_q;
        ch_in_d    = ch_in_q;
        ch1_d      = ch1_q;
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        cfg_err_d  = cfg_we & (state_q != IDLE);

        if (in_fire) begin
            in_cnt_d = in_cnt_q + HWORD'(1);
            ch_in_d  = ({1'b0, ch_in_q} == num_ch_q - (CW+1)'(1)) ? '0 : ch_in_q + CW'(1);
        end
        if (out_fire) begin
            out_cnt_d = out_cnt_q + HWORD'(1);
        end

        // Stage register and output register advance together; a stall freezes both.
        if (!stall) begin
            s1_valid_d = in_fire;
            s2_valid_d = s1_valid_q;
            ch1_d      = ch_in_q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    num_ch_d  = num_ch;
                    num_out_d = num_out;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    ch_in_d   = '0;
                    state_d   = (num_out == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (in_cnt_d == num_out_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_cnt_d == num_out_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            num_ch_q   <= '0;
            num_out_q  <= '0;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            ch_in_q    <= '0;
            ch1_q      <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_ch_q   <= num_ch_d;
            num_out_q  <= num_out_d;
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            ch_in_q    <= ch_in_d;
            ch1_q      <= ch1_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign s1_valid  = s1_valid_q;
    assign s2_valid  = s2_valid_q;
    assign out_valid = s2_valid_q;
    assign cfg_err   = cfg_err_q;
    assign p1_mult   = p1_param.mult;
    assign p2_shift  = p2_param.shift;
    assign p2_zp     = p2_param.zp;
    assign busy      = (state_q == RUN) | (state_q == DRAIN);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_requan_seq_ctrl.sv
// Scoreboard bench for requan_seq_ctrl: directed tiles push expected channel
// parameters on every accepted input; a negedge monitor pops and compares.
module tb_requan_seq_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [CW-1:0] cfg_idx;
    logic [15:0]   cfg_mult;
    logic [4:0]    cfg_shift;
    logic [7:0]    cfg_zp;
    logic          cfg_err;
    logic          start;
    logic [CW:0]   num_ch;
    logic [15:0]   num_out;
    logic          in_valid;
    logic          in_ready;
    logic          stall;
    logic          s1_valid;
    logic          s2_valid;
    logic [15:0]   p1_mult;
    logic [4:0]    p2_shift;
    logic [7:0]    p2_zp;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] sh_mult  [16];
    logic [4:0]  sh_shift [16];
    logic [7:0]  sh_zp    [16];
    int          m_ch     = 0;
    int          m_numch  = 1;
    int          in_seq   = 0;
    logic [12:0] p2_q [$];
    int          tok_q [$];

    always #5 clk = ~clk;

    requan_seq_ctrl #(.CH_MAX(16), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_mult  (cfg_mult),
        .cfg_shift (cfg_shift),
        .cfg_zp    (cfg_zp),
        .cfg_err   (cfg_err),
        .start     (start),
        .num_ch    (num_ch),
        .num_out   (num_out),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .stall     (stall),
        .s1_valid  (s1_valid),
        .s2_valid  (s2_valid),
        .p1_mult   (p1_mult),
        .p2_shift  (p2_shift),
        .p2_zp     (p2_zp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: p1 checked at acceptance, p2 when the stage register
    // hands its element to Requan2, output tokens on every out_fire.
    always @(negedge clk) begin
        if (rst) begin
            if (in_valid && in_ready) begin
                check_output("p1_mult", 32'(p1_mult), 32'(sh_mult[m_ch]));
                p2_q.push_back({sh_shift[m_ch], sh_zp[m_ch]});
                tok_q.push_back(in_seq);
                in_seq++;
                m_ch = (m_ch + 1 == m_numch) ? 0 : m_ch + 1;
            end
            if (s1_valid && !stall) begin
                check_output("p2_pending", 32'(p2_q.size() != 0), 32'd1);
                if (p2_q.size() != 0) begin
                    logic [12:0] e;
                    e = p2_q.pop_front();
                    check_output("p2_shift", 32'(p2_shift), 32'(e[12:8]));
                    check_output("p2_zp", 32'(p2_zp), 32'(e[7:0]));
                end
            end
            if (out_valid && out_ready) begin
                check_output("out_token", 32'(tok_q.size() != 0), 32'd1);
                if (tok_q.size() != 0) begin
                    void'(tok_q.pop_front());
                end
            end
        end
    end

    task automatic write_entries();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            cfg_we    = 1'b1;
            cfg_idx   = CW'(i);
            cfg_mult  = 16'h0100 + 16'(i);
            cfg_shift = 5'(i);
            cfg_zp    = 8'h10 + 8'(i);
            sh_mult[i]  = 16'h0100 + 16'(i);
            sh_shift[i] = 5'(i);
            sh_zp[i]    = 8'h10 + 8'(i);
        end
        @(posedge clk); #1;
        cfg_we = 1'b0;
        @(negedge clk);
        check_output("cfg_err_idle", 32'(cfg_err), 32'd0);
    endtask

    task automatic apply_stimulus(input int n_ch, input int n_out, input bit do_stall, input bit do_cfg);
        int ins = 0, outs = 0, last_out = -10, stall_left = 0, cfg_phase = 0;
        bit stall_used = 0, cfg_used = 0, unstall_chk = 0, drain_chk = 0, done_seen = 0;
        @(posedge clk); #1;
        start = 1'b1; num_ch = 5'(n_ch); num_out = 16'(n_out);
        in_valid = 1'b1; out_ready = 1'b1;
        m_ch = 0; m_numch = n_ch;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (cyc == 0) check_output("busy_run", 32'(busy), 32'd1);
            if (ins == n_out && !drain_chk) begin
                check_output("in_ready_drain", 32'(in_ready), 32'd0);
                drain_chk = 1;
            end
            if (stall_left > 0) begin
                check_output("stall_hi", 32'(stall), 32'd1);
                check_output("in_ready_stall", 32'(in_ready), 32'd0);
                check_output("out_valid_hold", 32'(out_valid), 32'd1);
                check_output("p2_shift_hold", 32'(p2_shift), 32'd0);
                check_output("p2_zp_hold", 32'(p2_zp), 32'h10);
                stall_left--;
            end else if (unstall_chk) begin
                check_output("stall_lo", 32'(stall), 32'd0);
                unstall_chk = 0;
            end
            if (cfg_phase == 1) begin
                cfg_phase = 2;
            end else if (cfg_phase == 2) begin
                check_output("cfg_err_pulse", 32'(cfg_err), 32'd1);
                cfg_phase = 3;
            end else if (cfg_phase == 3) begin
                check_output("cfg_err_end", 32'(cfg_err), 32'd0);
                cfg_phase = 0;
            end
            if (in_valid && in_ready) ins++;
            if (out_valid && out_ready) begin
                outs++;
                last_out = cyc;
            end
            if (done) begin
                done_seen = 1;
                check_output("done_latency", 32'(cyc - last_out), 32'd1);
                check_output("out_count", 32'(outs), 32'(n_out));
                check_output("in_count", 32'(ins), 32'(n_out));
                break;
            end
            @(posedge clk); #1;
            cfg_we = 1'b0;
            if (stall_left == 0 && !out_ready) begin
                out_ready   = 1'b1;
                unstall_chk = 1;
            end
            if (do_stall && !stall_used && outs == 3) begin
                out_ready  = 1'b0;
                stall_left = 3;
                stall_used = 1;
            end
            if (do_cfg && !cfg_used && ins == 2) begin
                cfg_we = 1'b1; cfg_idx = 4'd2; cfg_mult = 16'hDEAD;
                cfg_shift = 5'd31; cfg_zp = 8'hFF;
                cfg_used = 1; cfg_phase = 1;
            end
        end
        if (!done_seen) check_output("done_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        check_output("done_pulse_end", 32'(done), 32'd0);
        check_output("busy_idle", 32'(busy), 32'd0);
        check_output("p2_q_empty", 32'(p2_q.size()), 32'd0);
        check_output("tok_q_empty", 32'(tok_q.size()), 32'd0);
    endtask

    task automatic zero_tile();
        @(posedge clk); #1;
        start = 1'b1; num_ch = 5'd4; num_out = 16'd0; in_valid = 1'b1;
        @(negedge clk);
        check_output("zero_in_ready0", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check_output("zero_done", 32'(done), 32'd1);
        check_output("zero_in_ready1", 32'(in_ready), 32'd0);
        check_output("zero_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check_output("zero_done_end", 32'(done), 32'd0);
        check_output("zero_in_ready2", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
    endtask

    task automatic reset_mid_tile();
        int ins = 0;
        @(posedge clk); #1;
        start = 1'b1; num_ch = 5'd4; num_out = 16'd8;
        in_valid = 1'b1; out_ready = 1'b1; m_ch = 0; m_numch = 4;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 20 && ins < 3; cyc++) begin
            @(negedge clk);
            if (in_valid && in_ready) ins++;
        end
        check_output("reset_ins", 32'(ins), 32'd3);
        #1 rst = 1'b0;
        #1;
        check_output("rst_in_ready", 32'(in_ready), 32'd0);
        check_output("rst_stall", 32'(stall), 32'd0);
        check_output("rst_s1_valid", 32'(s1_valid), 32'd0);
        check_output("rst_s2_valid", 32'(s2_valid), 32'd0);
        check_output("rst_out_valid", 32'(out_valid), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_p1_mult", 32'(p1_mult), 32'd0);
        check_output("rst_p2_zp", 32'(p2_zp), 32'd0);
        p2_q.delete();
        tok_q.delete();
        for (int i = 0; i < 16; i++) begin
            sh_mult[i] = '0; sh_shift[i] = '0; sh_zp[i] = '0;
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_output("post_rst_done", 32'(done), 32'd0);
            check_output("post_rst_busy", 32'(busy), 32'd0);
        end
        check_output("tbl_cleared", 32'(p1_mult), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        rst = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_mult = '0; cfg_shift = '0; cfg_zp = '0;
        start = 1'b0; num_ch = '0; num_out = '0; in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sh_mult[i] = '0; sh_shift[i] = '0; sh_zp[i] = '0;
        end
        repeat (2) @(negedge clk);
        check_output("reset_in_ready", 32'(in_ready), 32'd0);
        check_output("reset_out_valid", 32'(out_valid), 32'd0);
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_done", 32'(done), 32'd0);
        check_output("reset_cfg_err", 32'(cfg_err), 32'd0);
        rst = 1'b1;
        write_entries();
        $display("[TB] basic tile");
        apply_stimulus(4, 8, 1'b0, 1'b0);
        $display("[TB] stalled tile");
        apply_stimulus(4, 8, 1'b1, 1'b0);
        $display("[TB] config write during run");
        apply_stimulus(4, 8, 1'b0, 1'b1);
        apply_stimulus(4, 8, 1'b0, 1'b0);
        $display("[TB] empty tile");
        zero_tile();
        $display("[TB] reset mid-tile");
        reset_mid_tile();
        write_entries();
        $display("[TB] full channel wrap");
        apply_stimulus(16, 20, 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
